// File: rtl/pll_sup_pkg.sv
// Shared state type, default parameters and width helper for the PLL lock supervisor.
// The optional lock-loss counter is enabled by defining PLL_SUP_LOSS_CNT_EN.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PULSE,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_sup_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_MAX_RETRIES   = 4;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // Width needed to hold 0..v, never narrower than one bit.
  function automatic int cnt_width(input int v);
    return ($clog2(v + 1) > 0) ? $clog2(v + 1) : 1;
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into refclk.
// Synchronous active-high reset clears both stages.
module pll_sup_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for stable lock, releases downstream reset.
// Define PLL_SUP_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clr,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt
);

  localparam int PW = cnt_width(RST_CYCLES);
  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int TW = cnt_width(LOCK_TIMEOUT);
  localparam int RW = cnt_width(MAX_RETRIES);

  logic           lk;
  pll_sup_state_t state_q, state_d;
  logic [PW-1:0]  pulse_q, pulse_d;
  logic [SW-1:0]  stable_q, stable_d;
  logic [TW-1:0]  timeout_q, timeout_d;
  logic [RW-1:0]  retry_q, retry_d;

  pll_sup_sync u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // clr overrides every state; lock presence takes priority over a timeout in WAIT_LOCK.
  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;
    retry_d   = retry_q;
    if (clr) begin
      state_d = PULSE;
      pulse_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        PULSE: begin
          if (pulse_q == PW'(RST_CYCLES - 1)) begin
            state_d   = WAIT_LOCK;
            pulse_d   = '0;
            timeout_d = '0;
            retry_d   = retry_q + RW'(1);
          end else begin
            pulse_d = pulse_q + PW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_d  = STABLE;
            stable_d = '0;
          end else if (timeout_q == TW'(LOCK_TIMEOUT - 1)) begin
            state_d = (retry_q < RW'(MAX_RETRIES)) ? PULSE : FAULT;
            pulse_d = '0;
          end else begin
            timeout_d = timeout_q + TW'(1);
          end
        end
        STABLE: begin
          if (!lk) begin
            state_d   = WAIT_LOCK;
            timeout_d = '0;
          end else if (stable_q == SW'(STABLE_CYCLES - 1)) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            state_d = PULSE;
            pulse_d = '0;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = PULSE;
          pulse_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PULSE;
      pulse_q   <= '0;
      stable_q  <= '0;
      timeout_q <= '0;
      retry_q   <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
      retry_q   <= retry_d;
      pll_rst   <= (state_d == PULSE) || (state_d == FAULT);
      sys_rst   <= (state_d != RUN);
      ready     <= (state_d == RUN);
      fault     <= (state_d == FAULT);
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  assign loss_evt = (state_q == RUN) && !lk;

  // Counted even when clr arrives on the same cycle; clr never clears it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != LOSS_CNT_MAX)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with a phase/elapsed-time reference model.
// Expected lock_loss_cnt follows PLL_SUP_LOSS_CNT_EN as seen by this compile.
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int SC = 8;
  localparam int LT = 32;
  localparam int MR = 2;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

`ifdef PLL_SUP_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clr = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [7:0] lock_loss_cnt;
  logic [11:0] dut_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: current phase, the edge it was entered on, pulses since last release.
  int   ph = PH_PULSE;
  int   since = 0;
  int   pulses = 0;
  int   losses = 0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;

  pll_lock_supervisor #(
    .RST_CYCLES    (RC),
    .STABLE_CYCLES (SC),
    .LOCK_TIMEOUT  (LT),
    .MAX_RETRIES   (MR)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .clr           (clr),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fault         (fault),
    .lock_loss_cnt (lock_loss_cnt)
  );

  assign dut_out = {pll_rst, sys_rst, ready, fault, lock_loss_cnt};

  always #5 refclk = ~refclk;

  function automatic logic [11:0] model_out();
    logic [7:0] l;
    l = LOSS_EN ? 8'(losses) : 8'd0;
    return {(ph == PH_PULSE) || (ph == PH_FAULT), ph != PH_RUN, ph == PH_RUN, ph == PH_FAULT, l};
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic pl);
    logic lk;
    int   age;
    lk  = s2;
    age = cyc - since;
    if (r) begin
      s1 = 1'b0; s2 = 1'b0;
      ph = PH_PULSE; since = cyc; pulses = 0; losses = 0;
      return;
    end
    s2 = s1;
    s1 = pl;
    if (ph == PH_RUN && !lk && losses < 255) losses++;
    if (c) begin
      pulses = 0; ph = PH_PULSE; since = cyc;
    end else begin
      case (ph)
        PH_PULSE:  if (age == RC) begin pulses++; ph = PH_WAIT; since = cyc; end
        PH_WAIT: begin
          if (lk) begin ph = PH_STABLE; since = cyc; end
          else if (age == LT) begin ph = (pulses < MR) ? PH_PULSE : PH_FAULT; since = cyc; end
        end
        PH_STABLE: begin
          if (!lk) begin ph = PH_WAIT; since = cyc; end
          else if (age == SC) begin pulses = 0; ph = PH_RUN; since = cyc; end
        end
        PH_RUN:    if (!lk) begin ph = PH_PULSE; since = cyc; end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    cyc++;
    model_edge(rst, clr, pll_locked);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; pll_locked = 1'b0;
    repeat (3) begin
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out()); end
    end
    total++;
    if (dut_out !== 12'hC00) begin bad++; $display("FAIL reset_values got=%h want=%h", dut_out, 12'hC00); end
    rst = 1'b0;
  endtask

  task automatic test_bringup();
    int   rdy_at;
    logic exp_p;
    rst = 1'b1; pll_locked = 1'b0; tick(); rst = 1'b0;
    rdy_at = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) pll_locked = 1'b1;
      tick();
      exp_p = (k < RC);
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL bringup_model k=%0d got=%h want=%h", k, dut_out, model_out()); end
      total++;
      if (pll_rst !== exp_p) begin bad++; $display("FAIL bringup_pll_rst k=%0d got=%b want=%b", k, pll_rst, exp_p); end
      if (ready && rdy_at < 0) rdy_at = k;
    end
    total++;
    if (rdy_at != 10 + 2 + SC) begin bad++; $display("FAIL bringup_ready_cycle got=%0d want=%0d", rdy_at, 10 + 2 + SC); end
  endtask

  task automatic test_glitch();
    int rdy_at, late_pulses;
    rst = 1'b1; pll_locked = 1'b0; tick(); rst = 1'b0;
    rdy_at = -1; late_pulses = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) pll_locked = 1'b1;
      if (k == 16) pll_locked = 1'b0;
      if (k == 17) pll_locked = 1'b1;
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL glitch_model k=%0d got=%h want=%h", k, dut_out, model_out()); end
      if (ready && rdy_at < 0) rdy_at = k;
      if (k >= RC && pll_rst) late_pulses++;
    end
    total++;
    if (rdy_at != 27) begin bad++; $display("FAIL glitch_ready_cycle got=%0d want=%0d", rdy_at, 27); end
    total++;
    if (late_pulses != 0) begin bad++; $display("FAIL glitch_no_pulse got=%0d want=0", late_pulses); end
  endtask

  task automatic test_run_loss();
    int sr_at, prst_cnt;
    logic got;
    pll_locked = 1'b0;
    sr_at = -1; prst_cnt = 0;
    for (int j = 1; j <= 15; j++) begin
      if (j == 8) pll_locked = 1'b1;
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL run_loss_model j=%0d got=%h want=%h", j, dut_out, model_out()); end
      if (sys_rst && !ready && sr_at < 0) sr_at = j;
      if (pll_rst) prst_cnt++;
    end
    total++;
    if (sr_at < 1 || sr_at > 3) begin bad++; $display("FAIL run_loss_sys_rst_latency got=%0d want=1..3", sr_at); end
    total++;
    if (prst_cnt != RC) begin bad++; $display("FAIL run_loss_pulse_len got=%0d want=%0d", prst_cnt, RC); end
    total++;
    if (lock_loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL run_loss_count got=%0d want=%0d", lock_loss_cnt, LOSS_EN ? 1 : 0); end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL run_loss_recover_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out()); end
      if (ready) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL run_loss_recover got=ready_low want=ready_high"); end
  endtask

  task automatic test_never_lock();
    int flt_at;
    rst = 1'b1; pll_locked = 1'b0; tick(); rst = 1'b0;
    flt_at = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL never_lock_model k=%0d got=%h want=%h", k, dut_out, model_out()); end
      if (fault && flt_at < 0) flt_at = k;
    end
    total++;
    if (flt_at != MR * (RC + LT)) begin bad++; $display("FAIL never_lock_fault_cycle got=%0d want=%0d", flt_at, MR * (RC + LT)); end
    total++;
    if ({fault, pll_rst, sys_rst} !== 3'b111) begin bad++; $display("FAIL never_lock_fault_hold got=%b want=111", {fault, pll_rst, sys_rst}); end
    clr = 1'b1; tick(); clr = 1'b0;
    total++;
    if ({fault, pll_rst} !== 2'b01) begin bad++; $display("FAIL never_lock_clr got=%b want=01", {fault, pll_rst}); end
    repeat (10) begin
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL never_lock_after_clr cyc=%0d got=%h want=%h", cyc, dut_out, model_out()); end
    end
  endtask

  task automatic test_clr_loss();
    logic got;
    rst = 1'b1; pll_locked = 1'b1; tick(); rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL clr_loss_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out()); end
      if (ready) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL clr_loss_reach_run got=ready_low want=ready_high"); end
    pll_locked = 1'b0;
    tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    total++;
    if (dut_out !== {4'b1100, (LOSS_EN ? 8'd1 : 8'd0)}) begin
      bad++; $display("FAIL clr_loss_same_cycle got=%h want=%h", dut_out, {4'b1100, (LOSS_EN ? 8'd1 : 8'd0)});
    end
  endtask

  task automatic test_saturation();
    logic got;
    rst = 1'b1; pll_locked = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        tick();
        total++;
        if (dut_out !== model_out()) begin bad++; $display("FAIL saturation_model n=%0d got=%h want=%h", n, dut_out, model_out()); end
        if (ready) got = 1'b1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL saturation_reach_run n=%0d got=ready_low want=ready_high", n); end
      pll_locked = 1'b0; tick(); pll_locked = 1'b1; tick(); tick();
    end
    repeat (3) tick();
    total++;
    if (lock_loss_cnt !== (LOSS_EN ? 8'd255 : 8'd0)) begin bad++; $display("FAIL saturation_count got=%0d want=%0d", lock_loss_cnt, LOSS_EN ? 255 : 0); end
  endtask

  task automatic test_reset_mid_wait();
    logic got;
    pll_locked = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); if (pll_rst) got = 1'b1; end
    for (int i = 0; i < 20 && got; i++) begin tick(); if (!pll_rst) got = 1'b0; end
    total++;
    if (got) begin bad++; $display("FAIL mid_wait_reach_wait got=pll_rst_high want=pll_rst_low"); end
    repeat (20) tick();
    total++;
    if (dut_out !== model_out()) begin bad++; $display("FAIL mid_wait_before_rst got=%h want=%h", dut_out, model_out()); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if (dut_out !== 12'hC00) begin bad++; $display("FAIL mid_wait_rst_values got=%h want=%h", dut_out, 12'hC00); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (pll_rst !== (k < RC)) begin bad++; $display("FAIL mid_wait_repulse k=%0d got=%b want=%b", k, pll_rst, (k < RC)); end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 40);
      end
      hold--;
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      total++;
      if (dut_out !== model_out()) begin bad++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out()); end
    end
    clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_run_loss();
    test_never_lock();
    test_clr_loss();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
